// File: rtl/cover_sched_pkg.sv
// cover_sched_pkg
//   Shared types and constants for the toggle-coverage report scheduler.
//   - state_t     : scheduler FSM states (IDLE, GRANT, EMIT)
//   - COVER_IDX_W : width of the absolute cover index (matches a longint sink)
//   - COAL_W      : width of the saturating coalesce counter
//   - sat_inc     : saturating +1 helper for the coalesce counter
package cover_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  localparam int COVER_IDX_W = 64;
  localparam int COAL_W      = 16;

  // Increment by one, sticking at all-ones.
  function automatic logic [COAL_W-1:0] sat_inc(input logic [COAL_W-1:0] v);
    return (v == {COAL_W{1'b1}}) ? v : (v + {{(COAL_W-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/cover_rr_arbiter.sv
// cover_rr_arbiter
//   Combinational round-robin arbiter. The search starts at last+1 (mod N)
//   and walks upward; the first requester found wins.
//   Ports:
//     req     in  [N-1:0]  request vector, one bit per group
//     last    in  [IW-1:0] most recently served group
//     gnt     out [N-1:0]  one-hot grant (all zero when no request)
//     gnt_idx out [IW-1:0] binary index of the granted group
//     any     out          at least one request present
module cover_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Rotated priority search: walk the ring backwards from the far end so the
  // final assignment left standing is the nearest requester after last.
  always_comb begin
    int pos_v;
    gnt_idx = {IW{1'b0}};
    pos_v   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      pos_v   = int'(last) + 1 + i;
      pos_v   = (pos_v >= N) ? (pos_v - N) : pos_v;
      gnt_idx = req[pos_v[IW-1:0]] ? pos_v[IW-1:0] : gnt_idx;
    end
  end

  // Request summary and one-hot expansion of the winning index.
  always_comb begin
    any = |req;
    gnt = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      gnt[k] = any && (gnt_idx == IW'(k));
    end
  end

endmodule

// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched
//   Serialises toggle-coverage hits from NUM_GROUPS groups of GROUP_W bits
//   onto a single valid/ready report port carrying an absolute cover index.
//   Hits are latched into pending bits; a round-robin arbiter picks a group
//   and the lowest pending bit in it is reported (one report per 2 cycles).
//   Optional build macro: COVER_SCHED_DEDUP_EN -- keeps a bitmap of reported
//   indices so each index is reported at most once per reset.
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   asynchronous active-low reset
//     en         in   capture enable (draining continues regardless)
//     valid      in   hit strobes, group g at [g*GROUP_W +: GROUP_W]
//     out_valid  out  report available
//     out_ready  in   sink accepts the report
//     out_index  out  absolute cover index, COVER_BASE + g*GROUP_W + b
//     coalesced  out  saturating count of cycles with hits on pending bits
//     idle       out  nothing pending and no report outstanding
module cover_toggle_sched
  import cover_sched_pkg::*;
#(
  parameter int NUM_GROUPS  = 4,
  parameter int GROUP_W     = 16,
  parameter int COVER_BASE  = 0,
  parameter int COVER_TOTAL = 38253
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           en,
  input  logic [NUM_GROUPS*GROUP_W-1:0]  valid,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COVER_IDX_W-1:0]         out_index,
  output logic [COAL_W-1:0]              coalesced,
  output logic                           idle
);

  localparam int TOTAL_W = NUM_GROUPS * GROUP_W;
  localparam int GIW     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int BIW     = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;

  generate
    if ((NUM_GROUPS < 1) || (NUM_GROUPS > 16)) begin : g_bad_groups
      $error("cover_toggle_sched: NUM_GROUPS must be 1..16");
    end
    if ((COVER_BASE + NUM_GROUPS * GROUP_W) > COVER_TOTAL) begin : g_bad_range
      $error("cover_toggle_sched: index range exceeds COVER_TOTAL");
    end
  endgenerate

  state_t             state_r;
  logic [TOTAL_W-1:0] pend_r;
  logic [TOTAL_W-1:0] clr_mask_r;
  logic [GIW-1:0]     grp_r;
  logic [GIW-1:0]     last_r;

  logic [TOTAL_W-1:0] clr_s;
  logic [TOTAL_W-1:0] cap_s;
  logic [TOTAL_W-1:0] pend_nxt_s;
  logic               coal_hit_s;
  logic               hs_s;

  logic [NUM_GROUPS-1:0] grp_req_s;
  logic [NUM_GROUPS-1:0] gnt_s;
  logic [GIW-1:0]        gnt_idx_s;
  logic                  gnt_any_s;

  logic [GROUP_W-1:0] sel_bits_s;
  logic [BIW-1:0]     bit_idx_s;
  int                 sel_pos_s;
  logic [TOTAL_W-1:0] sel_mask_s;

`ifdef COVER_SCHED_DEDUP_EN
  logic [TOTAL_W-1:0] covered_r;
`endif

  // Handshake and the one-bit clear it applies to the pending set.
  always_comb begin
    hs_s  = out_valid & out_ready;
    clr_s = hs_s ? clr_mask_r : {TOTAL_W{1'b0}};
  end

  // Capture mask, next pending value and the coalesce condition. The clear
  // is applied before the capture OR, so a same-cycle re-hit survives.
  always_comb begin
`ifdef COVER_SCHED_DEDUP_EN
    // The bit being reported this cycle counts as covered already.
    cap_s = en ? (valid & ~(covered_r | clr_s)) : {TOTAL_W{1'b0}};
`else
    cap_s = en ? valid : {TOTAL_W{1'b0}};
`endif
    pend_nxt_s = (pend_r & ~clr_s) | cap_s;
    coal_hit_s = |(cap_s & pend_r & ~clr_s);
  end

  // One request line per group: any pending bit inside it.
  always_comb begin
    grp_req_s = {NUM_GROUPS{1'b0}};
    for (int g = 0; g < NUM_GROUPS; g++) begin
      grp_req_s[g] = |pend_r[g*GROUP_W +: GROUP_W];
    end
  end

  cover_rr_arbiter #(
    .N  (NUM_GROUPS),
    .IW (GIW)
  ) u_arb (
    .req     (grp_req_s),
    .last    (last_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (gnt_any_s)
  );

  // Pull out the granted group's pending bits with the one-hot grant.
  always_comb begin
    sel_bits_s = {GROUP_W{1'b0}};
    for (int g = 0; g < NUM_GROUPS; g++) begin
      sel_bits_s = sel_bits_s |
                   (gnt_s[g] ? pend_r[g*GROUP_W +: GROUP_W] : {GROUP_W{1'b0}});
    end
  end

  // Lowest-set-bit encoder: scanning downward leaves the lowest hit in place.
  always_comb begin
    bit_idx_s = {BIW{1'b0}};
    for (int b = GROUP_W - 1; b >= 0; b--) begin
      bit_idx_s = sel_bits_s[b] ? BIW'(b) : bit_idx_s;
    end
  end

  // Flat position of the chosen bit and its one-hot clear mask.
  always_comb begin
    sel_pos_s  = (int'(gnt_idx_s) * GROUP_W) + int'(bit_idx_s);
    sel_mask_s = {TOTAL_W{1'b0}};
    for (int k = 0; k < TOTAL_W; k++) begin
      sel_mask_s[k] = (sel_pos_s == k);
    end
  end

  // Pending-bit register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_r <= {TOTAL_W{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Saturating coalesce counter: at most one step per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      coalesced <= {COAL_W{1'b0}};
    end else if (coal_hit_s) begin
      coalesced <= sat_inc(coalesced);
    end else begin
      coalesced <= coalesced;
    end
  end

`ifdef COVER_SCHED_DEDUP_EN
  // Bitmap of indices whose report has been accepted since reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      covered_r <= {TOTAL_W{1'b0}};
    end else begin
      covered_r <= covered_r | clr_s;
    end
  end
`endif

  // Scheduler FSM with registered report outputs and idle flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      out_valid  <= 1'b0;
      out_index  <= {COVER_IDX_W{1'b0}};
      clr_mask_r <= {TOTAL_W{1'b0}};
      grp_r      <= {GIW{1'b0}};
      last_r     <= GIW'(NUM_GROUPS - 1);
      idle       <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid <= 1'b0;
          idle      <= ~|pend_nxt_s;
          if (|pend_r) begin
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (gnt_any_s) begin
            out_index  <= COVER_IDX_W'(COVER_BASE) + COVER_IDX_W'(sel_pos_s);
            clr_mask_r <= sel_mask_s;
            grp_r      <= gnt_idx_s;
            out_valid  <= 1'b1;
            idle       <= 1'b0;
            state_r    <= ST_EMIT;
          end else begin
            out_valid <= 1'b0;
            idle      <= ~|pend_nxt_s;
            state_r   <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (hs_s) begin
            out_valid <= 1'b0;
            last_r    <= grp_r;
            idle      <= ~|pend_nxt_s;
            state_r   <= (|pend_nxt_s) ? ST_GRANT : ST_IDLE;
          end else begin
            // Hold the report untouched until the sink takes it.
            out_valid <= 1'b1;
            idle      <= 1'b0;
            state_r   <= ST_EMIT;
          end
        end
        default: begin
          out_valid <= 1'b0;
          idle      <= ~|pend_nxt_s;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cover_toggle_sched.sv
module tb_cover_toggle_sched;

  localparam int NG = 4;
  localparam int GW = 16;
  localparam int TW = NG * GW;

  logic          clock;
  logic          reset;
  logic          en;
  logic [TW-1:0] valid;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_index;
  logic [15:0]   coalesced;
  logic          idle;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];

  cover_toggle_sched #(
    .NUM_GROUPS  (NG),
    .GROUP_W     (GW),
    .COVER_BASE  (0),
    .COVER_TOTAL (38253)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .valid     (valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .coalesced (coalesced),
    .idle      (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: a handshake happens at the next rising edge.
  always @(negedge clock) begin
    logic [63:0] e;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL report_unexpected got index %0d, none expected", out_index);
      end else begin
        e = exp_q.pop_front();
        if (out_index !== e) begin
          miscompares++;
          $display("FAIL report_order got index %0d, expected %0d", out_index, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    valid     = '0;
    en        = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || idle !== 1'b1) && n < max_cycles) begin
      tick();
      n++;
    end
    repeat (4) tick();
    vectors++;
    if (exp_q.size() != 0 || idle !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_drain got %0d outstanding idle=%b, expected 0 outstanding idle=1",
               name, exp_q.size(), idle);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid);
    end
    vectors++;
    if (out_index !== 64'd0) begin
      miscompares++; $display("FAIL reset_out_index got %0d expected 0", out_index);
    end
    vectors++;
    if (coalesced !== 16'd0) begin
      miscompares++; $display("FAIL reset_coalesced got %0d expected 0", coalesced);
    end
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++; $display("FAIL reset_idle got %b expected 1", idle);
    end
  endtask

  task automatic test_single_hit();
    apply_reset();
    valid[5] = 1'b1;
    exp_q.push_back(64'd5);
    tick();                      // edge t: captured
    valid = '0;
    tick();                      // edge t+1: GRANT
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_early_valid got %b expected 0", out_valid);
    end
    tick();                      // edge t+2: report up
    vectors++;
    if (out_valid !== 1'b1 || out_index !== 64'd5) begin
      miscompares++;
      $display("FAIL single_report got valid=%b index=%0d expected valid=1 index=5",
               out_valid, out_index);
    end
    vectors++;
    if (idle !== 1'b0) begin
      miscompares++; $display("FAIL single_busy got idle=%b expected 0", idle);
    end
    tick();                      // edge t+3: handshake
    vectors++;
    if (idle !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle got idle=%b valid=%b expected idle=1 valid=0", idle, out_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    valid = 64'h0001_0001_0001_0001;
    for (int g = 0; g < NG; g++) exp_q.push_back(64'(g * GW));
    tick();
    valid = '0;
    wait_drain("round_robin", 40);
  endtask

  task automatic test_full_drain();
    apply_reset();
    valid = '1;
    for (int b = 0; b < GW; b++)
      for (int g = 0; g < NG; g++) exp_q.push_back(64'(g * GW + b));
    tick();
    valid = '0;
    wait_drain("full_drain", 300);
  endtask

  task automatic test_backpressure();
    bit stable = 1'b1;
    apply_reset();
    out_ready = 1'b0;
    valid[9] = 1'b1;
    exp_q.push_back(64'd9);
    tick();
    valid = '0;
    repeat (2) tick();
    // Three consecutive re-hits of the pending bit while stalled.
    valid[9] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) valid = '0;
      if (out_valid !== 1'b1 || out_index !== 64'd9) stable = 1'b0;
      tick();
    end
    vectors++;
    if (stable !== 1'b1 || out_valid !== 1'b1 || out_index !== 64'd9) begin
      miscompares++;
      $display("FAIL backpressure_hold got valid=%b index=%0d stable=%b expected valid=1 index=9 stable=1",
               out_valid, out_index, stable);
    end
    vectors++;
    if (coalesced !== 16'd3) begin
      miscompares++; $display("FAIL backpressure_coalesced got %0d expected 3", coalesced);
    end
    out_ready = 1'b1;
    wait_drain("backpressure", 20);
    vectors++;
    if (coalesced !== 16'd3) begin
      miscompares++; $display("FAIL backpressure_coal_after got %0d expected 3", coalesced);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    valid[7] = 1'b1;
    exp_q.push_back(64'd7);
`ifndef COVER_SCHED_DEDUP_EN
    exp_q.push_back(64'd7);
`endif
    tick();
    valid = '0;
    repeat (2) tick();           // report up, handshake at next edge
    valid[7] = 1'b1;             // re-hit lands in the handshake cycle
    tick();
    valid = '0;
    wait_drain("collision", 20);
    vectors++;
    if (coalesced !== 16'd0) begin
      miscompares++; $display("FAIL collision_coalesced got %0d expected 0", coalesced);
    end
  endtask

  task automatic test_reset_emit();
    apply_reset();
    valid[17] = 1'b1;            // serve group 1 so the pointer moves off reset
    exp_q.push_back(64'd17);
    tick();
    valid = '0;
    wait_drain("pre_reset", 20);
    out_ready = 1'b0;
    valid[33] = 1'b1;            // stalled report, later lost to reset
    tick();
    tick();                      // re-hit while pending: coalesced = 1
    valid = '0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_index !== 64'd33 || coalesced !== 16'd1) begin
      miscompares++;
      $display("FAIL pre_reset_emit got valid=%b index=%0d coal=%0d expected 1/33/1",
               out_valid, out_index, coalesced);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || coalesced !== 16'd0 || out_index !== 64'd0 || idle !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset got valid=%b coal=%0d index=%0d idle=%b expected 0/0/0/1",
               out_valid, coalesced, out_index, idle);
    end
    repeat (2) tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    valid[52] = 1'b1;
    valid[20] = 1'b1;
    exp_q.push_back(64'd20);     // search restarts at group 0
    exp_q.push_back(64'd52);
    tick();
    valid = '0;
    wait_drain("post_reset", 30);
  endtask

  task automatic test_en_gate();
    apply_reset();
    valid[3]  = 1'b1;
    valid[40] = 1'b1;
    exp_q.push_back(64'd3);
    exp_q.push_back(64'd40);
    tick();
    en    = 1'b0;
    valid = '1;
    repeat (5) tick();
    valid = '0;
    en    = 1'b1;
    wait_drain("en_gate", 30);
    vectors++;
    if (idle !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL en_gate_idle got idle=%b valid=%b expected 1/0", idle, out_valid);
    end
    vectors++;
    if (coalesced !== 16'd0) begin
      miscompares++; $display("FAIL en_gate_coalesced got %0d expected 0", coalesced);
    end
  endtask

  initial begin
    reset     = 1'b0;
    en        = 1'b1;
    valid     = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_hit();
    test_round_robin();
    test_full_drain();
    test_backpressure();
    test_collision();
    test_reset_emit();
    test_en_gate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cover_toggle_sched.md
# cover_toggle_sched

Scheduler that serialises toggle-coverage hits from several 16-bit coverage groups onto one shared report port, so a single DPI/report consumer sees one cover index per transfer. Each cycle's `valid` bits are latched into per-group pending registers. A round-robin arbiter grants one group, and the lowest pending bit of that group is emitted as an absolute cover index. The block sits between the per-module toggle probes and the coverage report sink.

## Interface
- `NUM_GROUPS`, default 4: number of 16-bit requester groups (1..16).
- `GROUP_W`, default 16: bits per group.
- `COVER_BASE`, default 0: index of group 0, bit 0. Group g, bit b maps to `COVER_BASE + g*GROUP_W + b`.
- `COVER_TOTAL`, default 38253: global index space; an elaboration check requires `COVER_BASE + NUM_GROUPS*GROUP_W <= COVER_TOTAL`.
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: capture enable; when 0, new hits are ignored.
- `valid`, in, `NUM_GROUPS*GROUP_W`: hit strobes; group g occupies bits `[g*GROUP_W +: GROUP_W]`.
- `out_valid`, out, 1: report available.
- `out_ready`, in, 1: sink accepts the report.
- `out_index`, out, 64: absolute cover index; matches the `longint` sink argument.
- `coalesced`, out, 16: saturating count of hits that landed on an already-pending bit.
- `idle`, out, 1: no pending bits and `out_valid` = 0.

## Operation
- Capture: `pend[g] <= (pend[g] & ~clr[g]) | (en ? valid_g : 0)`.
  - A set and a clear of the same bit in the same cycle leave the bit set; the set wins.
  - Capture is gated to 0 while `reset` is asserted.
- Coalesce: `coalesced` increments by 1 per cycle, not per bit, when any `valid & pend & ~clr` bit is nonzero. It saturates at 0xFFFF.
- FSM states: IDLE, GRANT, EMIT.
  - IDLE: if any `pend` is nonzero, go to GRANT.
  - GRANT: the round-robin arbiter picks the first group with a nonzero `pend`, searching upward from `last+1` mod `NUM_GROUPS`. Within that group the lowest set bit b is chosen. `out_index` and the clear mask are registered, and the FSM goes to EMIT.
  - EMIT: `out_valid` = 1. On `out_valid & out_ready`, clear the chosen bit, set `last = g`, then go to GRANT if other bits are still pending, otherwise to IDLE.
- `out_index` holds stable while `out_valid` = 1 and `out_ready` = 0. `out_valid` never drops without a handshake, except on reset.
- Reset values, applied asynchronously: `pend` = 0, state IDLE, `out_valid` = 0, `out_index` = 0, `coalesced` = 0, `last` = `NUM_GROUPS-1` so group 0 wins first, `idle` = 1.
- Reset asserted mid-EMIT drops the report; the hit is lost by design.

## Timing
- A hit sampled at edge t sets `pend` at t. GRANT occurs in cycle t+1, and `out_valid` is high from edge t+2. Minimum hit-to-report latency is 2 cycles.
- Throughput is one report per 2 cycles (GRANT then EMIT). The GRANT after a handshake sees the clear already applied.
- With `out_ready` held at 1 and all bits pending, the drain order is g0b0, g1b0, …, g(N-1)b0, g0b1, and so on.
- `en` affects capture only. Pending bits drain regardless of `en`.

## Configuration
- `COVER_SCHED_DEDUP_EN`, when defined: adds a `covered` bitmap of `NUM_GROUPS*GROUP_W` bits, reset to 0, set at each handshake.
  - Capture is masked with `~covered`, so each index is reported at most once per reset.
  - Masked hits do not increment `coalesced`.
- Without the macro: no bitmap. An index is re-reported whenever it is hit again after its report was accepted.

## Structure
- Package `cover_sched_pkg`: FSM state enum (IDLE, GRANT, EMIT), the `COVER_IDX_W` = 64 constant, and the coalesce-counter width.
- Sub-module `cover_rr_arbiter`, parameterised by N:
  - Inputs: request vector, `last` pointer.
  - Outputs: one-hot grant, grant index, `any`.
  - Purely combinational.
- The lowest-set-bit encoder stays inline in the top module.

## Test plan
- Single hit, `out_ready`=1: `valid`[5] pulsed at cycle 10 gives `out_valid` from edge 12 with `out_index`=5; `idle` returns to 1 at edge 13.
- Round-robin across groups: `valid` = 0x0001_0001_0001_0001 in one cycle gives reports 0, 16, 32, 48 in that order.
- Backpressure: `out_ready`=0 for 20 cycles gives `out_index` stable and `out_valid` held. Re-hitting the pending bit 3 times gives `coalesced`=3.
- Set/clear collision: re-hit bit 7 in the handshake cycle.
  - Without DEDUP, index 7 is reported twice.
  - With `COVER_SCHED_DEDUP_EN`, it is reported once and `coalesced` is unchanged.
- Reset during EMIT: pull `reset` low asynchronously mid-cycle. `out_valid`, `pend`, and `coalesced` go to 0 immediately. After release, the next hit on group 3 is granted normally, starting the search from group 0.
- `en`=0 with all `valid` high for 5 cycles produces no reports and `idle`=1. Pending bits captured before `en` fell still drain.
